// File: rtl/pool_if.sv
// Row stream between norm and the pooling stage: input row plus valid, and the
// registered output row plus its one-cycle valid pulse.
interface pool_if #(
    parameter int DWIDTH       = 8,
    parameter int MAT_MUL_SIZE = 4
);
    logic                             in_data_available;
    logic [MAT_MUL_SIZE*DWIDTH-1:0]   inp_data;
    logic [MAT_MUL_SIZE*DWIDTH-1:0]   out_data;
    logic                             out_data_available;

    modport master (
        output in_data_available,
        output inp_data,
        input  out_data,
        input  out_data_available
    );

    modport slave (
        input  in_data_available,
        input  inp_data,
        output out_data,
        output out_data_available
    );
endinterface

// File: rtl/pool.sv
// 2x2 signed max-pooling over a row stream, or a one-cycle registered
// pass-through when enable_pool is low. All outputs are registered.
module pool #(
    parameter int DWIDTH       = 8,
    parameter int MAT_MUL_SIZE = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   enable_pool,
    pool_if.slave  bus,
    output logic   done_pool
);
    localparam int HALF = MAT_MUL_SIZE / 2;
    localparam int RW   = MAT_MUL_SIZE * DWIDTH;
    localparam int HW   = HALF * DWIDTH;
    localparam int CW   = $clog2(MAT_MUL_SIZE);
    localparam logic [CW-1:0] RC_LAST = CW'(MAT_MUL_SIZE - 1);

    logic [CW-1:0] rc_q, rc_d, rc_eff;
    logic [HW-1:0] buf_q, buf_d;
    logic [RW-1:0] out_q, out_d;
    logic          vld_q, vld_d;
    logic          done_q, done_d;
    logic          mode_q, mode_d;

    logic [HW-1:0] h, p;
    logic signed [DWIDTH-1:0] ea, eb, hj, bj;

    // Horizontal max of each element pair, then vertical max against the buffered row.
    always_comb begin
        h  = '0;
        p  = '0;
        ea = '0;
        eb = '0;
        hj = '0;
        bj = '0;
        for (int j = 0; j < HALF; j++) begin
            ea = $signed(bus.inp_data[(2*j)*DWIDTH +: DWIDTH]);
            eb = $signed(bus.inp_data[(2*j+1)*DWIDTH +: DWIDTH]);
            hj = (ea >= eb) ? ea : eb;
            h[j*DWIDTH +: DWIDTH] = hj;
            bj = $signed(buf_q[j*DWIDTH +: DWIDTH]);
            p[j*DWIDTH +: DWIDTH] = (bj >= hj) ? bj : hj;
        end
    end

    // A mode change restarts the tile; the row arriving with it is row 0.
    assign rc_eff = (enable_pool != mode_q) ? '0 : rc_q;

    always_comb begin
        rc_d   = rc_eff;
        buf_d  = buf_q;
        out_d  = enable_pool ? out_q : bus.inp_data;
        vld_d  = 1'b0;
        done_d = done_q;
        mode_d = enable_pool;
        if (bus.in_data_available) begin
            rc_d = (rc_eff == RC_LAST) ? '0 : rc_eff + 1'b1;
            if (rc_eff == RC_LAST) begin
                done_d = 1'b1;
            end
            if (!enable_pool) begin
                vld_d = 1'b1;
            end else if (!rc_eff[0]) begin
                buf_d = h;
            end else begin
                out_d = {{(RW-HW){1'b0}}, p};
                vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rc_q   <= '0;
            buf_q  <= '0;
            out_q  <= '0;
            vld_q  <= 1'b0;
            done_q <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            rc_q   <= rc_d;
            buf_q  <= buf_d;
            out_q  <= out_d;
            vld_q  <= vld_d;
            done_q <= done_d;
            mode_q <= mode_d;
        end
    end

    assign bus.out_data           = out_q;
    assign bus.out_data_available = vld_q;
    assign done_pool              = done_q;
endmodule

// File: tb/tb_pool.sv
// Directed bench for pool with DWIDTH=8, MAT_MUL_SIZE=4; inputs are driven and
// outputs sampled on the falling edge.
module tb_pool;
    logic clk = 1'b0;
    logic reset;
    logic enable_pool;
    logic done_pool;
    int   n_checks = 0;
    int   n_errors = 0;

    pool_if #(.DWIDTH(8), .MAT_MUL_SIZE(4)) bus ();

    pool #(.DWIDTH(8), .MAT_MUL_SIZE(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable_pool (enable_pool),
        .bus         (bus),
        .done_pool   (done_pool)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] row(input int e0, input int e1, input int e2, input int e3);
        logic [7:0] b0, b1, b2, b3;
        b0 = 8'(e0);
        b1 = 8'(e1);
        b2 = 8'(e2);
        b3 = 8'(e3);
        return {b3, b2, b1, b0};
    endfunction

    // After this returns, outputs reflect the previous input cycle.
    task automatic cycle(input logic v, input logic [31:0] d);
        @(negedge clk);
        bus.in_data_available = v;
        bus.inp_data          = d;
    endtask

    task automatic do_reset(input logic en);
        @(negedge clk);
        reset                 = 1'b1;
        enable_pool           = en;
        bus.in_data_available = 1'b0;
        bus.inp_data          = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset                 = 1'b1;
        enable_pool           = 1'b0;
        bus.in_data_available = 1'b0;
        bus.inp_data          = '0;

        // Reset state
        do_reset(1'b0);
        check_eq("rst_data", bus.out_data, 32'h0);
        check_eq("rst_vld", {31'b0, bus.out_data_available}, 32'h0);
        check_eq("rst_done", {31'b0, done_pool}, 32'h0);

        // Pass-through
        cycle(1'b1, 32'h04030201);
        check_eq("pt_no_early", {31'b0, bus.out_data_available}, 32'h0);
        cycle(1'b0, 32'h0);
        check_eq("pt_data", bus.out_data, 32'h04030201);
        check_eq("pt_vld", {31'b0, bus.out_data_available}, 32'h1);
        cycle(1'b0, 32'h0);
        check_eq("pt_vld_drop", {31'b0, bus.out_data_available}, 32'h0);

        // Basic pool
        do_reset(1'b1);
        cycle(1'b1, row(1, 5, 2, 3));
        cycle(1'b1, row(4, 0, 7, 6));
        check_eq("bp_no_pulse_r0", {31'b0, bus.out_data_available}, 32'h0);
        cycle(1'b0, 32'h0);
        check_eq("bp_data", bus.out_data, 32'h00000705);
        check_eq("bp_vld", {31'b0, bus.out_data_available}, 32'h1);
        cycle(1'b0, 32'h0);
        check_eq("bp_vld_drop", {31'b0, bus.out_data_available}, 32'h0);
        check_eq("bp_hold", bus.out_data, 32'h00000705);

        // Signed compare
        do_reset(1'b1);
        cycle(1'b1, row(-1, -3, -128, -2));
        cycle(1'b1, row(-5, -4, -7, -6));
        cycle(1'b0, 32'h0);
        check_eq("sg_data", bus.out_data, 32'h0000FEFF);
        check_eq("sg_vld", {31'b0, bus.out_data_available}, 32'h1);
        do_reset(1'b1);
        cycle(1'b1, row(-128, -128, -128, -128));
        cycle(1'b1, row(-128, -128, -128, -128));
        cycle(1'b0, 32'h0);
        check_eq("sg_min_data", bus.out_data, 32'h00008080);
        check_eq("sg_min_vld", {31'b0, bus.out_data_available}, 32'h1);

        // Bubbles and full tile
        do_reset(1'b1);
        cycle(1'b1, row(1, 2, 3, 4));
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0);
            check_eq("bb_idle0", {31'b0, bus.out_data_available}, 32'h0);
        end
        cycle(1'b1, row(5, 6, 7, 8));
        cycle(1'b0, 32'h0);
        check_eq("bb_p0_data", bus.out_data, 32'h00000806);
        check_eq("bb_p0_vld", {31'b0, bus.out_data_available}, 32'h1);
        check_eq("bb_p0_done", {31'b0, done_pool}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 32'h0);
            check_eq("bb_idle1", {31'b0, bus.out_data_available}, 32'h0);
        end
        cycle(1'b1, row(9, 9, 0, 0));
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0);
            check_eq("bb_idle2", {31'b0, bus.out_data_available}, 32'h0);
            check_eq("bb_done_low", {31'b0, done_pool}, 32'h0);
        end
        cycle(1'b1, row(0, 0, 10, 1));
        cycle(1'b0, 32'h0);
        check_eq("bb_p1_data", bus.out_data, 32'h00000A09);
        check_eq("bb_p1_vld", {31'b0, bus.out_data_available}, 32'h1);
        check_eq("bb_p1_done", {31'b0, done_pool}, 32'h1);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 32'h0);
            check_eq("bb_done_sticky", {31'b0, done_pool}, 32'h1);
        end
        check_eq("bb_hold", bus.out_data, 32'h00000A09);

        // Reset mid-tile
        cycle(1'b1, row(9, 9, 9, 9));
        do_reset(1'b1);
        check_eq("rm_done", {31'b0, done_pool}, 32'h0);
        check_eq("rm_data", bus.out_data, 32'h0);
        cycle(1'b1, row(1, 0, 0, 0));
        cycle(1'b1, row(0, 0, 0, 2));
        check_eq("rm_no_pulse", {31'b0, bus.out_data_available}, 32'h0);
        cycle(1'b1, row(0, 0, 0, 0));
        check_eq("rm_data_out", bus.out_data, 32'h00000201);
        check_eq("rm_vld", {31'b0, bus.out_data_available}, 32'h1);
        check_eq("rm_done_r1", {31'b0, done_pool}, 32'h0);
        cycle(1'b1, row(0, 0, 0, 0));
        check_eq("rm_done_r2", {31'b0, done_pool}, 32'h0);
        cycle(1'b0, 32'h0);
        check_eq("rm_done_r3", {31'b0, done_pool}, 32'h1);

        // Enable toggle
        do_reset(1'b1);
        cycle(1'b1, row(1, 1, 1, 1));
        @(negedge clk);
        enable_pool           = 1'b0;
        bus.in_data_available = 1'b1;
        bus.inp_data          = 32'h0A0B0C0D;
        check_eq("et_no_pulse", {31'b0, bus.out_data_available}, 32'h0);
        cycle(1'b0, 32'h0);
        check_eq("et_pt_data", bus.out_data, 32'h0A0B0C0D);
        check_eq("et_pt_vld", {31'b0, bus.out_data_available}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0);
            check_eq("et_idle", {31'b0, bus.out_data_available}, 32'h0);
        end
        @(negedge clk);
        enable_pool           = 1'b1;
        bus.in_data_available = 1'b1;
        bus.inp_data          = row(2, 2, 2, 2);
        cycle(1'b1, row(3, 3, 3, 3));
        check_eq("et_restart_row0", {31'b0, bus.out_data_available}, 32'h0);
        cycle(1'b0, 32'h0);
        check_eq("et_pool_data", bus.out_data, 32'h00000303);
        check_eq("et_pool_vld", {31'b0, bus.out_data_available}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pool.md
# pool

2x2 max-pooling stage sitting directly downstream of `norm`. It consumes the row stream `norm` produces (`out_data` / `out_data_available`) and emits pooled rows toward the output-BRAM write stage. With `enable_pool` low it is a one-cycle registered pass-through, so the output mux never needs to bypass it.

## Interface

Parameters:
- `DWIDTH`, 8, element width in bits; elements are signed two's complement.
- `MAT_MUL_SIZE`, 4, elements per row and rows per tile. Must be even and ≥ 2.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `enable_pool`  in  1  from `cfg`.
  - 1 = pool.
  - 0 = pass-through.
  - Static while a tile is in flight.
- `in_data_available`  in  1  input row valid, one cycle per row.
- `inp_data`  in  `MAT_MUL_SIZE*DWIDTH`  input row; element i occupies bits `[i*DWIDTH +: DWIDTH]`.
- `out_data`  out  `MAT_MUL_SIZE*DWIDTH`  output row, same packing.
- `out_data_available`  out  1  output row valid, one-cycle pulse.
- `done_pool`  out  1  tile complete (sticky).

## Operation

Reset (sampled at a rising edge with `reset`=1):
- `out_data`=0, `out_data_available`=0, `done_pool`=0.
- Row counter = 0; row buffer = 0.

Pass-through (`enable_pool`=0):
- `out_data` <= `inp_data` and `out_data_available` <= `in_data_available`, every cycle.
- Row counter counts accepted rows exactly as in pool mode and drives `done_pool` identically.

Pool mode (`enable_pool`=1):
- Row counter `rc` counts 0..`MAT_MUL_SIZE`-1. It advances only on cycles with `in_data_available`=1 and wraps to 0 after `MAT_MUL_SIZE`-1.
- Horizontal max, per accepted row: `h[j] = max(e[2j], e[2j+1])` for j = 0..`MAT_MUL_SIZE`/2-1, signed compare.
- Even `rc`: store h[] in the row buffer. No output.
- Odd `rc`:
  - Compute `p[j] = max(buf[j], h[j])`, signed.
  - Register p[j] into element j of `out_data`.
  - Upper `MAT_MUL_SIZE`/2 elements of `out_data` = 0.
  - `out_data_available` <= 1.
- Cycles without `in_data_available`: `out_data_available` <= 0. `out_data` holds its value in pool mode; in pass-through it follows `inp_data`. `buf` and `rc` hold.
- Each tile yields `MAT_MUL_SIZE`/2 output rows.

Tile completion and `done_pool`:
- `done_pool` <= 1 in the same edge that accepts row `rc`=`MAT_MUL_SIZE`-1.
- In pool mode this coincides with the last `out_data_available` pulse.
- Stays 1 until `reset`. A later tile does not clear it.

Boundary conditions:
- Bubbles of any length between rows are allowed; the result is identical to back-to-back rows.
- `enable_pool` change while `rc`≠0: `rc` <= 0 and the buffer is discarded; the row on that cycle, if valid, is processed in the new mode as row 0. Tests must not rely on any other behaviour.
- `reset` mid-tile: the partial tile is dropped and no output is produced for it. The next valid row is row 0.
- Equal operands: the result is that value; tie order is irrelevant.
- Most-negative value (-2^(DWIDTH-1)) must compare correctly.

## Timing

- Latency: input row valid at edge N → output valid after edge N+1 (one register stage), both modes.
- Throughput:
  - Pass-through: one row per cycle.
  - Pool mode: one output per two input rows.
- No backpressure. The downstream write stage must accept every `out_data_available` pulse.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan

All scenarios use `DWIDTH`=8, `MAT_MUL_SIZE`=4; row element lists are written e0..e3.

- **Pass-through:** `enable_pool`=0, row 0x04030201 valid for one cycle → next cycle `out_data`=0x04030201 and `out_data_available`=1 for exactly one cycle.
- **Basic pool:** rows [1,5,2,3] then [4,0,7,6] back-to-back → one cycle after the second row, `out_data`=0x00000705 with `out_data_available`=1; no pulse after the first row.
- **Signed compare:** rows [-1,-3,-128,-2] then [-5,-4,-7,-6] → `out_data`=0x0000FEFF. Also rows all -128 → 0x00008080.
- **Bubbles and full tile:** four rows [1,2,3,4], [5,6,7,8], [9,9,0,0], [0,0,10,1], each separated by 3 idle cycles →
  - Two pulses, values 0x00000806 then 0x00000A09.
  - `done_pool` rises with the second pulse and stays high for 20 further cycles.
- **Reset mid-tile:** pool one row [9,9,9,9], assert `reset` for one cycle, then rows [1,0,0,0], [0,0,0,2] → one output 0x00000201. `done_pool`=0 after the reset and remains 0 until the 4th row after reset.
- **Enable toggle:** pool one row, drop `enable_pool`, send row 0x0A0B0C0D → next cycle pass-through `out_data`=0x0A0B0C0D; no pooled output is ever emitted for the dropped row.
